bin2bcd_gen: RTL
================

// Module: bin2bcd_gen
// PURPOSE
// Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
// Converts a BIN_W-bit value, unsigned or two's-complement, into DIGITS packed BCD digits.
// Adds a sign output, an overflow flag and per-digit leading-zero blanking.
// Sits between datapath counters/registers and seven-segment/UART display formatters.
// PARAMETERS
// BIN_W   16  binary input width; legal range 2..32
// DIGITS   5  number of BCD digits produced; legal range >=1; may be smaller than needed (see overflow)
// PORTS
// clk          in   1          system clock, rising edge
// reset_n      in   1          asynchronous, active-low reset
// start        in   1          request conversion; sampled only while ready=1
// signed_mode  in   1          1: bin is two's-complement; 0: bin is unsigned; sampled with start
// bin          in   BIN_W      value to convert; sampled with start
// ready        out  1          idle, able to accept start
// done_tick    out  1          one-cycle pulse; results updated this cycle
// sign         out  1          1 = result negative (signed_mode and bin[BIN_W-1])
// overflow     out  1          magnitude > 10^DIGITS-1; bcd holds magnitude mod 10^DIGITS
// bcd          out  4*DIGITS   packed digits, digit 0 (units) in [3:0]
// blank        out  DIGITS     bit i=1: digit i is a leading zero; bit 0 always 0
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, ready=1, done_tick=0, sign=0, overflow=0, bcd=0, blank=0,
//   all internal shift/count registers 0. Any conversion in progress is abandoned, no done_tick.
// - FSM states IDLE, OP, DONE:
//   IDLE: ready=1. start=1 -> latch magnitude into shift reg (negate if signed_mode & bin MSB; set
//         sign_tmp), clear working digits and sticky overflow, counter=BIN_W, go OP.
//   OP:   ready=0. Each cycle: every working digit >4 gets +3 (4-bit wrap), then {digits,shift}<<1,
//         shift-reg MSB enters digit 0 LSB; bit leaving top digit MSB ORs into sticky overflow;
//         counter-1; when next counter==0 go DONE. Exactly BIN_W OP cycles.
//   DONE: ready=0, done_tick=1; result regs (bcd, sign, overflow, blank) load from working regs; -> IDLE.
// - Latency: start accepted in cycle 0 -> OP cycles 1..BIN_W -> done_tick in cycle BIN_W+1 ->
//   ready=1 in cycle BIN_W+2. Results change only in the cycle after done_tick; stable otherwise.
// - start while ready=0 is ignored (not queued). start held high in IDLE after DONE starts a new
//   conversion; back-to-back throughput one result per BIN_W+2 cycles.
// - Magnitude: most-negative input -2^(BIN_W-1) gives magnitude 2^(BIN_W-1) in BIN_W bits, sign=1.
//   Zero input with signed_mode=1: sign=0.
// - Blank: computed at DONE from working digits; bit i (i>=1) = 1 when digits i..DIGITS-1 all zero.
//   Value 0 -> blank = all ones except bit 0. With overflow=1 blank reflects truncated digits.
// - Counter width $clog2(BIN_W+1); no other arithmetic widens.
// - Illegal FSM encoding -> IDLE next cycle.
// STRUCTURE
// - Package bin2bcd_pkg: typedef enum {IDLE, OP, DONE} b2b_state_t; function
//   bcd_adj3(logic [3:0]) returns digit>4 ? digit+3 : digit.
// - Sub-module bcd_digit_adj (combinational, one 4-bit digit in, adjusted digit out).
//   Instantiate DIGITS copies with a generate loop.
// - Top: FSMD with separate state/data registers and next-state block; result registers
//   distinct from working registers.
// TESTING
// - Default params: unsigned bin=16'hFFFF -> after 18 cycles done_tick, bcd=20'h65535, overflow=0,
//   sign=0, blank=5'b00000.
// - signed_mode=1, bin=16'h8000 -> sign=1, bcd=20'h32768; bin=16'hFFF9 -> sign=1, bcd=20'h00007,
//   blank=5'b11110.
// - DIGITS=4, BIN_W=16, bin=12345 -> overflow=1, bcd=16'h2345; bin=9999 -> overflow=0, bcd=16'h9999.
// - bin=0 -> bcd=0, blank=5'b11110, sign=0 in both modes.
// - start pulsed during OP with different bin -> ignored; first result unchanged; ready low
//   throughout.
// - reset_n low mid-OP -> all outputs zero immediately, ready=1, no done_tick; new start after
//   release converts correctly.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } b2b_state_t;

  // Double-dabble correction: a digit of 5..9 is pre-biased so the following shift carries out.
  function automatic logic [3:0] bcd_adj3(input logic [3:0] digit);
    return (digit > 4'd4) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin2bcd_gen_bcd_digit_adj.sv
// Combinational add-3 correction for one working BCD digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = bcd_adj3(digit_in);

endmodule

// File: rtl/bin2bcd_gen.sv
// Sequential shift-and-add-3 binary-to-BCD converter with sign, overflow and
// leading-zero blanking; one result every BIN_W+2 cycles.
module bin2bcd_gen
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  sign,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  b2b_state_t state_q, state_d;

  logic [BIN_W-1:0]       shift_q;
  logic [4*DIGITS-1:0]    digits_q;
  logic [4*DIGITS-1:0]    digits_adj;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sign_tmp_q;
  logic                   ovf_q;

  logic                   neg;
  logic signed [BIN_W-1:0] bin_s;
  logic [BIN_W-1:0]       mag;
  logic [DIGITS-1:0]      blank_w;

  // Negating the most-negative value wraps to 2^(BIN_W-1), which is the correct magnitude.
  assign neg   = signed_mode & bin[BIN_W-1];
  assign bin_s = $signed(bin);
  assign mag   = neg ? $unsigned(-bin_s) : bin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (digits_q[4*g +: 4]),
      .digit_out (digits_adj[4*g +: 4])
    );
  end

  always_comb begin
    blank_w = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blank_w[i] = ((digits_q >> (4 * i)) == '0);
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? OP : IDLE;
      OP:      state_d = (cnt_q == CNT_W'(1)) ? DONE : OP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready     <= (state_d == IDLE);
      done_tick <= (state_d == DONE);
    end
  end

  // Working registers shift during OP; result registers only load on leaving DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      digits_q   <= '0;
      cnt_q      <= '0;
      sign_tmp_q <= 1'b0;
      ovf_q      <= 1'b0;
      bcd        <= '0;
      sign       <= 1'b0;
      overflow   <= 1'b0;
      blank      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q    <= mag;
            digits_q   <= '0;
            cnt_q      <= CNT_W'(BIN_W);
            sign_tmp_q <= neg;
            ovf_q      <= 1'b0;
          end
        end
        OP: begin
          digits_q <= {digits_adj[4*DIGITS-2:0], shift_q[BIN_W-1]};
          shift_q  <= shift_q << 1;
          ovf_q    <= ovf_q | digits_adj[4*DIGITS-1];
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bcd      <= digits_q;
          sign     <= sign_tmp_q;
          overflow <= ovf_q;
          blank    <= blank_w;
        end
        default: ;
      endcase
    end
  end

endmodule
